// File: rtl/pattern_pwm_pkg.sv
// Shared state encoding, default widths and config helpers for the multi-channel pattern PWM.
package pattern_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_GAP  = 2'd2,
    ST_END  = 2'd3
  } pwm_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_PAT_W  = 16;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_BIT_W  = 8;
  localparam int DEF_GAP_W  = 16;
  localparam int DEF_REP_W  = 8;

  // Lengths beyond the pattern register fall back to the full register.
  function automatic int clamp_len(int len, int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_pwm_ch.sv
// One pattern PWM engine: serialises a snapshotted bit pattern with bit time, gap and repeat
// control, plus graceful stop and immediate abort. All outputs are registered.
module pattern_pwm_ch
  import pattern_pwm_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int BIT_W = DEF_BIT_W,
  parameter int GAP_W = DEF_GAP_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [BIT_W-1:0] bit_cycles,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic [REP_W-1:0] rep_num,
  input  logic             idle_level,
  output logic             pwm_out,
  output logic             busy,
  output logic             done
);

  pwm_state_e       state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q, bit_idx_q, bit_idx_d, len_in;
  logic [BIT_W-1:0] bc_q, cyc_cnt_q;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;
  logic [REP_W-1:0] rep_q, rep_cnt_q, rep_cnt_d;
  logic             idle_q, stop_pend_q, stop_pend_d;
  logic             pwm_q, busy_q, done_q;
  logic [PAT_W-1:0] nxt_pat;
  logic             last_bit, bit_done, rep_hit, gap_done;

  assign len_in = LEN_W'(clamp_len(int'(pat_len), PAT_W - 1));

  always_comb begin
    stop_pend_d = stop_pend_q | stop;
    // Saturate so a rep_num at the field maximum is still reachable.
    rep_cnt_d   = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q + 1'b1;
    nxt_pat     = pat_q >> bit_idx_d;
    last_bit    = (bit_idx_q == len_q);
    bit_done    = (cyc_cnt_q == bc_q);
    rep_hit     = (rep_q != '0) && (rep_cnt_d == rep_q);
    gap_done    = (gap_cnt_q == gap_q - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pwm_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      bit_idx_q   <= '0;
      cyc_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      bc_q        <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      idle_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pwm_q  <= idle_level;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q     <= ST_BIT;
            pwm_q       <= pat[0];
            busy_q      <= 1'b1;
            pat_q       <= pat;
            len_q       <= len_in;
            bc_q        <= bit_cycles;
            gap_q       <= gap_cycles;
            rep_q       <= rep_num;
            idle_q      <= idle_level;
            bit_idx_q   <= '0;
            cyc_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
          end
        end
        ST_BIT: begin
          stop_pend_q <= stop_pend_d;
          if (abort) begin
            state_q <= ST_END;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pwm_q   <= idle_q;
          end else if (!bit_done) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end else if (!last_bit) begin
            cyc_cnt_q <= '0;
            bit_idx_q <= bit_idx_d;
            pwm_q     <= nxt_pat[0];
          end else begin
            cyc_cnt_q <= '0;
            bit_idx_q <= '0;
            rep_cnt_q <= rep_cnt_d;
            if (stop_pend_d || rep_hit) begin
              state_q <= ST_END;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pwm_q   <= idle_q;
            end else if (gap_q != '0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= '0;
              pwm_q     <= idle_q;
            end else begin
              pwm_q <= pat_q[0];
            end
          end
        end
        ST_GAP: begin
          stop_pend_q <= stop_pend_d;
          // A stop arriving in the gap has no pattern left to finish.
          if (abort || stop_pend_d) begin
            state_q <= ST_END;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pwm_q   <= idle_q;
          end else if (gap_done) begin
            state_q <= ST_BIT;
            pwm_q   <= pat_q[0];
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_END: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pwm_q   <= idle_level;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pwm_out = pwm_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: rtl/pattern_pwm_mc.sv
// Multi-channel pattern PWM: NUM_CH independent engines; channel c owns bus slice [c*W +: W].
module pattern_pwm_mc
  import pattern_pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int BIT_W  = DEF_BIT_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int REP_W  = DEF_REP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*PAT_W-1:0] pat,
  input  logic [NUM_CH*LEN_W-1:0] pat_len,
  input  logic [NUM_CH*BIT_W-1:0] bit_cycles,
  input  logic [NUM_CH*GAP_W-1:0] gap_cycles,
  input  logic [NUM_CH*REP_W-1:0] rep_num,
  input  logic [NUM_CH-1:0]       idle_level,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pattern_pwm_ch #(
      .PAT_W(PAT_W),
      .LEN_W(LEN_W),
      .BIT_W(BIT_W),
      .GAP_W(GAP_W),
      .REP_W(REP_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start     (start[c]),
      .stop      (stop[c]),
      .abort     (abort[c]),
      .pat       (pat[c*PAT_W +: PAT_W]),
      .pat_len   (pat_len[c*LEN_W +: LEN_W]),
      .bit_cycles(bit_cycles[c*BIT_W +: BIT_W]),
      .gap_cycles(gap_cycles[c*GAP_W +: GAP_W]),
      .rep_num   (rep_num[c*REP_W +: REP_W]),
      .idle_level(idle_level[c]),
      .pwm_out   (pwm_out[c]),
      .busy      (busy[c]),
      .done      (done[c])
    );
  end

endmodule

// File: tb/tb_pattern_pwm_mc.sv
// Randomised bench for pattern_pwm_mc: a timeline model predicts every output cycle into a
// queue; a monitor pops and compares one entry per clock.
module tb_pattern_pwm_mc;
  localparam int NUM_CH = 4;
  localparam int PAT_W  = 8;
  localparam int LEN_W  = 4;
  localparam int BIT_W  = 8;
  localparam int GAP_W  = 16;
  localparam int REP_W  = 8;
  localparam longint INF = 64'h3fff_ffff_ffff_ffff;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       start, stop, abort, idle_level;
  logic [NUM_CH*PAT_W-1:0] pat;
  logic [NUM_CH*LEN_W-1:0] pat_len;
  logic [NUM_CH*BIT_W-1:0] bit_cycles;
  logic [NUM_CH*GAP_W-1:0] gap_cycles;
  logic [NUM_CH*REP_W-1:0] rep_num;
  logic [NUM_CH-1:0]       pwm_out, busy, done;

  pattern_pwm_mc #(
    .NUM_CH(NUM_CH), .PAT_W(PAT_W), .LEN_W(LEN_W),
    .BIT_W(BIT_W), .GAP_W(GAP_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
    .pat(pat), .pat_len(pat_len), .bit_cycles(bit_cycles), .gap_cycles(gap_cycles),
    .rep_num(rep_num), .idle_level(idle_level),
    .pwm_out(pwm_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint edge_n = 0;

  // Per-channel run description: start edge, end offset and snapshotted config.
  bit     act  [NUM_CH];
  longint s_e  [NUM_CH];
  longint k_end[NUM_CH];
  int     m_pat[NUM_CH], m_len[NUM_CH], m_bc[NUM_CH], m_gap[NUM_CH], m_rep[NUM_CH];
  bit     m_idle[NUM_CH];

  function automatic longint blen(int c);
    return longint'(m_len[c] + 1) * longint'(m_bc[c] + 1);
  endfunction

  task automatic model_push();
    exp_t   e;
    longint kp, k, bl, per, r, w;
    int     lf;
    edge_n++;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        act[c] = 1'b0;
        continue;
      end
      kp  = edge_n - 1 - s_e[c];
      bl  = blen(c);
      per = bl + m_gap[c];
      if (act[c] && kp >= 0 && kp < k_end[c]) begin
        if (abort[c]) k_end[c] = kp + 1;
        else if (stop[c]) begin
          r = kp / per;
          w = kp % per;
          if (w < bl) begin
            if (r * per + bl < k_end[c]) k_end[c] = r * per + bl;
          end else k_end[c] = kp + 1;
        end
      end
      if ((!act[c] || kp > k_end[c]) && start[c] && !abort[c]) begin
        act[c]    = 1'b1;
        s_e[c]    = edge_n;
        m_pat[c]  = int'(pat[c*PAT_W +: PAT_W]);
        lf        = int'(pat_len[c*LEN_W +: LEN_W]);
        m_len[c]  = (lf > PAT_W - 1) ? PAT_W - 1 : lf;
        m_bc[c]   = int'(bit_cycles[c*BIT_W +: BIT_W]);
        m_gap[c]  = int'(gap_cycles[c*GAP_W +: GAP_W]);
        m_rep[c]  = int'(rep_num[c*REP_W +: REP_W]);
        m_idle[c] = idle_level[c];
        bl        = blen(c);
        per       = bl + m_gap[c];
        k_end[c]  = (m_rep[c] == 0) ? INF : longint'(m_rep[c]) * per - m_gap[c];
      end
      k = edge_n - s_e[c];
      if (act[c] && k < k_end[c]) begin
        e.busy[c] = 1'b1;
        w = k % per;
        e.pwm[c] = (w < bl) ? m_pat[c][int'(w / (m_bc[c] + 1))] : m_idle[c];
      end else if (act[c] && k == k_end[c]) begin
        e.done[c] = 1'b1;
        e.pwm[c]  = m_idle[c];
      end else begin
        e.pwm[c] = idle_level[c];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_push();
    @(negedge clk);
    start = '0;
    stop  = '0;
    abort = '0;
    rst   = 1'b0;
  endtask

  task automatic set_cfg(int c, int p, int l, int b, int g, int r, bit id);
    pat[c*PAT_W +: PAT_W]        = PAT_W'(p);
    pat_len[c*LEN_W +: LEN_W]    = LEN_W'(l);
    bit_cycles[c*BIT_W +: BIT_W] = BIT_W'(b);
    gap_cycles[c*GAP_W +: GAP_W] = GAP_W'(g);
    rep_num[c*REP_W +: REP_W]    = REP_W'(r);
    idle_level[c]                = id;
  endtask

  task automatic rand_cfg(int c);
    int b, g, r;
    b = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
    g = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 400)) : int'($urandom_range(0, 3));
    r = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4));
    set_cfg(c, int'($urandom), int'($urandom_range(0, 15)), b, g, r, 1'($urandom));
  endtask

  // Monitor: one expected entry per clock, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({pwm_out, busy, done} !== mon_e) begin
          errors++;
          $display("FAIL outputs @%0t pwm/busy/done: got %b/%b/%b expected %b/%b/%b",
                   $time, pwm_out, busy, done, mon_e.pwm, mon_e.busy, mon_e.done);
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      act[c] = 1'b0; s_e[c] = 0; k_end[c] = 0;
      m_pat[c] = 0; m_len[c] = 0; m_bc[c] = 0; m_gap[c] = 0; m_rep[c] = 0; m_idle[c] = 1'b0;
    end
    start = '0; stop = '0; abort = '0;
    pat = '0; pat_len = '0; bit_cycles = '0; gap_cycles = '0; rep_num = '0; idle_level = '0;
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      step();
    end

    // Basic pattern with gap and two repeats.
    set_cfg(0, 'b101, 2, 0, 1, 2, 1'b0);
    start[0] = 1'b1; step();
    repeat (10) step();
    // Single long bit, idle high.
    set_cfg(1, 'h01, 0, 3, 0, 1, 1'b1);
    start[1] = 1'b1; step();
    repeat (8) step();
    // Infinite run, stop mid-pattern, then stop inside the gap.
    set_cfg(2, 'b1011, 3, 1, 2, 0, 1'b0);
    start[2] = 1'b1; step();
    repeat (3) step();
    stop[2] = 1'b1; step();
    repeat (15) step();
    start[2] = 1'b1; step();
    repeat (8) step();
    stop[2] = 1'b1; step();
    repeat (5) step();
    // Abort mid-run, then abort coincident with start in idle.
    set_cfg(3, 'h5a, 7, 2, 3, 0, 1'b1);
    start[3] = 1'b1; step();
    repeat (5) step();
    abort[3] = 1'b1; step();
    repeat (3) step();
    start[3] = 1'b1; abort[3] = 1'b1; step();
    repeat (3) step();
    // Phase-aligned start on all channels, retrigger and config change mid-run.
    for (int c = 0; c < NUM_CH; c++) set_cfg(c, 'hc6, 7, 1, 2, 2, 1'b0);
    start = '1; step();
    repeat (3) step();
    for (int c = 0; c < NUM_CH; c++) rand_cfg(c);
    start[1] = 1'b1; step();
    repeat (40) step();
    // Reset mid-run, then a length field beyond the pattern width.
    set_cfg(0, 'h3c, 5, 1, 0, 0, 1'b1);
    start[0] = 1'b1; step();
    repeat (5) step();
    rst = 1'b1; step();
    step();
    set_cfg(0, 'ha5, 15, 0, 0, 1, 1'b0);
    start[0] = 1'b1; step();
    repeat (12) step();

    for (int i = 0; i < 20000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) rand_cfg(c);
        start[c] = ($urandom_range(0, 5) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
        abort[c] = ($urandom_range(0, 69) == 0);
      end
      rst = ($urandom_range(0, 799) == 0);
      step();
    end

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
